// File: rtl/gyro_resp_pkg.sv
// Shared definitions for the Pmod GYRO SPI responder: register map, command bits, FSM states.
package gyro_resp_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_CTRL2    = 6'h21;
    localparam logic [5:0] ADDR_CTRL3    = 6'h22;
    localparam logic [5:0] ADDR_CTRL4    = 6'h23;
    localparam logic [5:0] ADDR_CTRL5    = 6'h24;
    localparam logic [5:0] ADDR_TEMP     = 6'h26;
    localparam logic [5:0] ADDR_STATUS   = 6'h27;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned CMD_MS_BIT = 6;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    function automatic logic is_ctrl_addr(input logic [5:0] a);
        return (a >= ADDR_CTRL1) && (a <= ADDR_CTRL5);
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Synchronizes sclk/slave_select/mosi into the clk domain and produces
// single-cycle rise/fall pulses for sclk and slave_select.
module spi_slave_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic ss_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_rise_o,
    output logic ss_fall_o,
    output logic ss_level_o,
    output logic mosi_level_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    // slave_select resets to "seen low" so a frame already in progress at
    // reset produces no fall; only a genuine rise re-arms the responder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '1;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_o  =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o  = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign ss_rise_o    =  ss_sync_q[SYNC_STAGES-1]   & ~ss_prev_q;
    assign ss_fall_o    = ~ss_sync_q[SYNC_STAGES-1]   &  ss_prev_q;
    assign ss_level_o   =  ss_sync_q[SYNC_STAGES-1];
    assign mosi_level_o =  mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gyro_spi_responder.sv
// SPI mode-3 responder emulating the Pmod GYRO (L3G4200D) register map.
// Optional STATUS_REG at 0x27 is built when GYRO_RESP_STATUS_EN is defined.
module gyro_spi_responder
    import gyro_resp_pkg::*;
#(
    parameter logic [7:0]  WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0]  CTRL1_RST    = 8'h07,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        slave_select,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] x_axis_in,
    input  logic [15:0] y_axis_in,
    input  logic [15:0] z_axis_in,
    input  logic [7:0]  temp_in,
    input  logic        sample_valid,
    output logic [7:0]  ctrl_reg1,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic        busy
);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_lvl, mosi_lvl;

    spi_slave_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i       (clk),
        .rst_i       (rst),
        .sclk_i      (sclk),
        .ss_n_i      (slave_select),
        .mosi_i      (mosi),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ss_rise_o   (ss_rise),
        .ss_fall_o   (ss_fall),
        .ss_level_o  (ss_lvl),
        .mosi_level_o(mosi_lvl)
    );

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      tx_q, tx_d;
    logic            miso_q, miso_d;
    logic            rw_q, rw_d;
    logic            ms_q, ms_d;
    logic [5:0]      addr_q, addr_d;
    logic [4:0][7:0] ctrl_q, ctrl_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [5:0]      wr_addr_q, wr_addr_d;
    logic            busy_q, busy_d;
    logic            armed_q, armed_d;
    logic [15:0]     lat_x_q, lat_x_d, lat_y_q, lat_y_d, lat_z_q, lat_z_d;
    logic [7:0]      lat_t_q, lat_t_d;
    logic [15:0]     snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;
    logic [7:0]      snap_t_q, snap_t_d;
    logic [7:0]      rx_byte;
    logic [5:0]      next_addr;

`ifdef GYRO_RESP_STATUS_EN
    logic zyxda_q, zyxor_q, status_clr;

    assign status_clr = armed_q && (state_q == DATA) && !ss_rise && sclk_rise &&
                        (bit_cnt_q == 3'd7) && rw_q && (addr_q == ADDR_OUT_Z_H);

    // A new sample in the same cycle as the Z_H read-out keeps ZYXDA set.
    always_ff @(posedge clk) begin
        if (rst) begin
            zyxda_q <= 1'b0;
            zyxor_q <= 1'b0;
        end else if (sample_valid) begin
            zyxda_q <= 1'b1;
            zyxor_q <= zyxor_q | zyxda_q;
        end else if (status_clr) begin
            zyxda_q <= 1'b0;
            zyxor_q <= 1'b0;
        end
    end
`endif

    function automatic logic [7:0] reg_read(input logic [5:0] a);
        logic [7:0] v;
        v = '0;
        case (a)
            ADDR_WHO_AM_I: v = WHO_AM_I_VAL;
            ADDR_CTRL1:    v = ctrl_q[0];
            ADDR_CTRL2:    v = ctrl_q[1];
            ADDR_CTRL3:    v = ctrl_q[2];
            ADDR_CTRL4:    v = ctrl_q[3];
            ADDR_CTRL5:    v = ctrl_q[4];
            ADDR_TEMP:     v = snap_t_q;
`ifdef GYRO_RESP_STATUS_EN
            ADDR_STATUS:   v = {zyxor_q, 3'b000, zyxda_q, 3'b000};
`endif
            ADDR_OUT_X_L:  v = snap_x_q[7:0];
            ADDR_OUT_X_H:  v = snap_x_q[15:8];
            ADDR_OUT_Y_L:  v = snap_y_q[7:0];
            ADDR_OUT_Y_H:  v = snap_y_q[15:8];
            ADDR_OUT_Z_L:  v = snap_z_q[7:0];
            ADDR_OUT_Z_H:  v = snap_z_q[15:8];
            default:       v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        rw_d        = rw_q;
        ms_d        = ms_q;
        addr_d      = addr_q;
        ctrl_d      = ctrl_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        busy_d      = busy_q;
        armed_d     = armed_q;
        lat_x_d     = lat_x_q;
        lat_y_d     = lat_y_q;
        lat_z_d     = lat_z_q;
        lat_t_d     = lat_t_q;
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_z_d    = snap_z_q;
        snap_t_d    = snap_t_q;
        rx_byte     = {rx_q[6:0], mosi_lvl};
        next_addr   = ms_q ? addr_q + 6'd1 : addr_q;

        if (sample_valid) begin
            lat_x_d = x_axis_in;
            lat_y_d = y_axis_in;
            lat_z_d = z_axis_in;
            lat_t_d = temp_in;
        end

        if (!armed_q) begin
            armed_d = ss_lvl;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_d   = CMD;
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                        miso_d    = 1'b0;
                        // Bypass so a sample arriving with the select fall is the one served.
                        snap_x_d  = sample_valid ? x_axis_in : lat_x_q;
                        snap_y_d  = sample_valid ? y_axis_in : lat_y_q;
                        snap_z_d  = sample_valid ? z_axis_in : lat_z_q;
                        snap_t_d  = sample_valid ? temp_in   : lat_t_q;
                    end
                end
                default: begin
                    if (ss_rise) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        miso_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        if (sclk_fall) begin
                            if (state_q == CMD) begin
                                miso_d = 1'b0;
                            end else begin
                                miso_d = tx_q[7];
                                tx_d   = {tx_q[6:0], 1'b0};
                            end
                        end
                        if (sclk_rise) begin
                            rx_d      = rx_byte;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == CMD) begin
                                    state_d = DATA;
                                    rw_d    = rx_byte[CMD_RW_BIT];
                                    ms_d    = rx_byte[CMD_MS_BIT];
                                    addr_d  = rx_byte[5:0];
                                    tx_d    = rx_byte[CMD_RW_BIT] ? reg_read(rx_byte[5:0]) : '0;
                                end else begin
                                    addr_d = next_addr;
                                    if (rw_q) begin
                                        tx_d = reg_read(next_addr);
                                    end else if (is_ctrl_addr(addr_q)) begin
                                        wr_strobe_d = 1'b1;
                                        wr_addr_d   = addr_q;
                                        case (addr_q)
                                            ADDR_CTRL1: ctrl_d[0] = rx_byte;
                                            ADDR_CTRL2: ctrl_d[1] = rx_byte;
                                            ADDR_CTRL3: ctrl_d[2] = rx_byte;
                                            ADDR_CTRL4: ctrl_d[3] = rx_byte;
                                            default:    ctrl_d[4] = rx_byte;
                                        endcase
                                    end
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b1;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= '0;
            ctrl_q      <= {32'h0, CTRL1_RST};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            lat_x_q     <= '0;
            lat_y_q     <= '0;
            lat_z_q     <= '0;
            lat_t_q     <= '0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_z_q    <= '0;
            snap_t_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            armed_q     <= armed_d;
            lat_x_q     <= lat_x_d;
            lat_y_q     <= lat_y_d;
            lat_z_q     <= lat_z_d;
            lat_t_q     <= lat_t_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_z_q    <= snap_z_d;
            snap_t_q    <= snap_t_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = busy_q;
    assign ctrl_reg1 = ctrl_q[0];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Self-checking bench for gyro_spi_responder: acts as a mode-3 SPI master.
// STATUS_REG checks are built when GYRO_RESP_STATUS_EN is defined.
module tb_gyro_spi_responder;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b1;
    logic        slave_select = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe;
    logic [15:0] x_axis_in = '0, y_axis_in = '0, z_axis_in = '0;
    logic [7:0]  temp_in = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  ctrl_reg1;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic        busy;

    gyro_spi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .slave_select(slave_select),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .x_axis_in   (x_axis_in),
        .y_axis_in   (y_axis_in),
        .z_axis_in   (z_axis_in),
        .temp_in     (temp_in),
        .sample_valid(sample_valid),
        .ctrl_reg1   (ctrl_reg1),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;

    always @(negedge clk) if (wr_strobe) strobe_cnt++;

    typedef struct {
        string           name;
        int              n;
        logic [0:6][7:0] tx;
        logic [0:6][7:0] exp;
    } vec_t;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic add_vec(input string name, input int n, input logic [55:0] tx, input logic [55:0] exp);
        vec_t v;
        v.name = name;
        v.n    = n;
        v.tx   = tx;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic xfer(input logic [7:0] t, input int nb, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            sclk = 1'b0;
            mosi = t[7-i];
            #(HALF);
            sclk = 1'b1;
            r[7-i] = miso;
            #(HALF);
        end
    endtask

    task automatic pulse_sv();
        sample_valid = 1'b1;
        #10;
        sample_valid = 1'b0;
        #10;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [55:0] tx_in,
                             input logic [55:0] exp_in, input bit is_read, input bit inject);
        logic [0:6][7:0] tx;
        logic [0:6][7:0] ex;
        logic [7:0]      r;
        exp_t            e;
        tx = tx_in;
        ex = exp_in;
        if (is_read) begin
            for (int k = 1; k < n; k++) begin
                e.tag = $sformatf("%s_b%0d", tag, k);
                e.v   = ex[k];
                sb_q.push_back(e);
            end
        end
        slave_select = 1'b0;
        #(HALF);
        check({tag, "_busy_oe"}, {30'd0, busy, miso_oe}, 32'd3);
        for (int k = 0; k < n; k++) begin
            xfer(tx[k], 8, r);
            if (inject && k == 2) begin
                x_axis_in = 16'h5678;
                y_axis_in = 16'h9ABC;
                z_axis_in = 16'h7FFF;
                pulse_sv();
            end
            if (is_read && k > 0) begin
                if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
                else begin
                    e = sb_q.pop_front();
                    check(e.tag, {24'd0, r}, {24'd0, e.v});
                end
            end
        end
        #(HALF);
        slave_select = 1'b1;
        #200;
        check({tag, "_idle"}, {29'd0, busy, miso_oe, miso}, 32'd1);
    endtask

    initial begin
        int         s0;
        logic [7:0] r;

        // Reset state
        #100;
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_ctrl1", {24'd0, ctrl_reg1}, 32'h07);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #100;

        // Master setup write
        s0 = strobe_cnt;
        run_frame("setup_wr", 2, 56'h20_0F_00_00_00_00_00, '0, 1'b0, 1'b0);
        check("setup_ctrl1", {24'd0, ctrl_reg1}, 32'h0F);
        check("setup_strobes", strobe_cnt - s0, 32'd1);
        check("setup_wr_addr", {26'd0, wr_addr}, 32'h20);

        x_axis_in = 16'h1234;
        y_axis_in = 16'hABCD;
        z_axis_in = 16'h8001;
        temp_in   = 8'h5A;
        pulse_sv();

        add_vec("whoami",   2, 56'h8F_00_00_00_00_00_00, 56'h00_D3_00_00_00_00_00);
        add_vec("ctrl1_rd", 2, 56'hA0_00_00_00_00_00_00, 56'h00_0F_00_00_00_00_00);
        add_vec("axes",     7, 56'hE8_00_00_00_00_00_00, 56'h00_34_12_CD_AB_01_80);
        add_vec("temp",     2, 56'hA6_00_00_00_00_00_00, 56'h00_5A_00_00_00_00_00);
        add_vec("wrap",     3, 56'hFF_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00);
        add_vec("ms_cross", 4, 56'hDF_00_00_00_00_00_00, 56'h00_00_0F_00_00_00_00);
        add_vec("ms0_hold", 3, 56'h8F_00_00_00_00_00_00, 56'h00_D3_D3_00_00_00_00);
        add_vec("reg27",    2, 56'hA7_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00);
        add_vec("unmapped", 2, 56'hA5_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00);
        add_vec("x_l",      2, 56'hA8_00_00_00_00_00_00, 56'h00_34_00_00_00_00_00);
        foreach (vecs[i]) run_frame(vecs[i].name, vecs[i].n, vecs[i].tx, vecs[i].exp, 1'b1, 1'b0);

        // New sample mid-frame leaves the snapshot alone; next frame sees it
        run_frame("mid_sv", 7, 56'hE8_00_00_00_00_00_00, 56'h00_34_12_CD_AB_01_80, 1'b1, 1'b1);
        run_frame("post_sv", 7, 56'hE8_00_00_00_00_00_00, 56'h00_78_56_BC_9A_FF_7F, 1'b1, 1'b0);

        // Partial data byte is discarded
        s0 = strobe_cnt;
        slave_select = 1'b0;
        #(HALF);
        xfer(8'h21, 8, r);
        xfer(8'hFF, 4, r);
        #(HALF);
        slave_select = 1'b1;
        #200;
        check("partial_strobes", strobe_cnt - s0, 32'd0);
        run_frame("partial_rd", 2, 56'hA1_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00, 1'b1, 1'b0);

        // Write bursts: incrementing, read-only target, and held address
        s0 = strobe_cnt;
        run_frame("wr_inc", 3, 56'h61_AA_BB_00_00_00_00, '0, 1'b0, 1'b0);
        check("wr_inc_strobes", strobe_cnt - s0, 32'd2);
        check("wr_inc_addr", {26'd0, wr_addr}, 32'h22);
        run_frame("rd_inc", 3, 56'hE1_00_00_00_00_00_00, 56'h00_AA_BB_00_00_00_00, 1'b1, 1'b0);
        s0 = strobe_cnt;
        run_frame("wr_ro", 2, 56'h0F_77_00_00_00_00_00, '0, 1'b0, 1'b0);
        check("wr_ro_strobes", strobe_cnt - s0, 32'd0);
        run_frame("rd_ro", 2, 56'h8F_00_00_00_00_00_00, 56'h00_D3_00_00_00_00_00, 1'b1, 1'b0);
        s0 = strobe_cnt;
        run_frame("wr_hold", 3, 56'h24_11_22_00_00_00_00, '0, 1'b0, 1'b0);
        check("wr_hold_strobes", strobe_cnt - s0, 32'd2);
        check("wr_hold_addr", {26'd0, wr_addr}, 32'h24);
        run_frame("rd_hold", 2, 56'hA4_00_00_00_00_00_00, 56'h00_22_00_00_00_00_00, 1'b1, 1'b0);

        // Reset mid-frame: rest of the frame must be ignored
        s0 = strobe_cnt;
        slave_select = 1'b0;
        #(HALF);
        xfer(8'h20, 3, r);
        rst = 1'b1;
        #30;
        rst = 1'b0;
        xfer(8'h00, 5, r);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        xfer(8'h20, 8, r);
        xfer(8'h55, 8, r);
        check("midrst_busy2", {30'd0, busy, miso_oe}, 32'd0);
        #(HALF);
        slave_select = 1'b1;
        #200;
        check("midrst_ctrl1", {24'd0, ctrl_reg1}, 32'h07);
        check("midrst_strobes", strobe_cnt - s0, 32'd0);
        run_frame("midrst_ctrl2", 2, 56'hA1_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00, 1'b1, 1'b0);
        s0 = strobe_cnt;
        run_frame("midrst_wr", 2, 56'h20_0F_00_00_00_00_00, '0, 1'b0, 1'b0);
        check("midrst_wr_ctrl1", {24'd0, ctrl_reg1}, 32'h0F);
        check("midrst_wr_strobes", strobe_cnt - s0, 32'd1);

`ifdef GYRO_RESP_STATUS_EN
        run_frame("st_clear0", 7, 56'hE8_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00, 1'b1, 1'b0);
        pulse_sv();
        run_frame("st_one", 2, 56'hA7_00_00_00_00_00_00, 56'h00_08_00_00_00_00_00, 1'b1, 1'b0);
        pulse_sv();
        run_frame("st_two", 2, 56'hA7_00_00_00_00_00_00, 56'h00_88_00_00_00_00_00, 1'b1, 1'b0);
        run_frame("st_zread", 7, 56'hE8_00_00_00_00_00_00, 56'h00_78_56_BC_9A_FF_7F, 1'b1, 1'b0);
        run_frame("st_cleared", 2, 56'hA7_00_00_00_00_00_00, 56'h00_00_00_00_00_00_00, 1'b1, 1'b0);
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
